// File: rtl/rpll_seq.sv
// Ring-PLL bring-up / retention sequencer: bias settle, optional fastlock, filtered lock,
// auto-relock with bounded retries, periodic retention training, fault and enable-drop abort.
module rpll_seq #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RETRY_W     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               locked,
  input  logic               core_ret,
  input  logic               ret_mode_locked,
  input  logic [7:0]         swi_bias_settle_count,
  input  logic [7:0]         swi_pre_locking_count,
  input  logic [7:0]         swi_lock_filt_count,
  input  logic               swi_skip_fastlock,
  input  logic               swi_disable_lock_det_after_lock,
  input  logic               swi_auto_relock,
  input  logic [RETRY_W-1:0] swi_max_retry,
  input  logic [CNT_W-1:0]   swi_ret_per_training_wait,
  input  logic [CNT_W-1:0]   swi_ret_per_training_time,
  input  logic [CNT_W-1:0]   swi_ret_exit_timeout,
  output logic               pll_en,
  output logic               pll_reset,
  output logic               pll_ret,
  output logic               en_lock_det,
  output logic               en_fastlock,
  output logic               en_ret_lock_det,
  output logic               fastlock_ready,
  output logic               ready,
  output logic               loss_of_lock,
  output logic               ret_exit_timeout,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lol_count,
  output logic [3:0]         fsm_state
);

  localparam int unsigned NUM_ASYNC = 4;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    BIAS_SETTLE   = 4'd1,
    FASTLOCKING   = 4'd2,
    PRE_LOCKING   = 4'd3,
    LOCKING       = 4'd4,
    PLL_LOCKED    = 4'd5,
    RETEN         = 4'd6,
    RETEN_PER     = 4'd7,
    RETEN_LOCKING = 4'd8,
    FAULT         = 4'd9
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0][NUM_ASYNC-1:0] sync_q;
  logic enable_s, locked_s, core_ret_s, ret_mode_locked_s;

  logic [CNT_W-1:0]   count, count_n;
  logic [7:0]         filt, filt_n;
  logic               pll_en_n, pll_reset_n, pll_ret_n;
  logic               en_lock_det_n, en_fastlock_n, en_ret_lock_det_n;
  logic               fastlock_ready_n, ready_n, loss_of_lock_n;
  logic               ret_exit_timeout_n, fault_n;
  logic [RETRY_W-1:0] retry_count_n;
  logic [7:0]         lol_count_n;
  logic               go_idle;
  logic               lock_qual;
  logic               lock_lost;

  assign {ret_mode_locked_s, core_ret_s, locked_s, enable_s} = sync_q[SYNC_STAGES-1];
  assign fsm_state = 4'(state);

  assign lock_qual = locked_s && (filt == swi_lock_filt_count);
  assign lock_lost = !locked_s && !swi_disable_lock_det_after_lock;

  // State, counters, synchronisers and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q           <= '0;
      state            <= IDLE;
      count            <= '0;
      filt             <= '0;
      pll_en           <= 1'b0;
      pll_reset        <= 1'b1;
      pll_ret          <= 1'b0;
      en_lock_det      <= 1'b0;
      en_fastlock      <= 1'b0;
      en_ret_lock_det  <= 1'b0;
      fastlock_ready   <= 1'b0;
      ready            <= 1'b0;
      loss_of_lock     <= 1'b0;
      ret_exit_timeout <= 1'b0;
      fault            <= 1'b0;
      retry_count      <= '0;
      lol_count        <= '0;
    end else begin
      sync_q           <= {sync_q[SYNC_STAGES-2:0], {ret_mode_locked, core_ret, locked, enable}};
      state            <= state_n;
      count            <= count_n;
      filt             <= filt_n;
      pll_en           <= pll_en_n;
      pll_reset        <= pll_reset_n;
      pll_ret          <= pll_ret_n;
      en_lock_det      <= en_lock_det_n;
      en_fastlock      <= en_fastlock_n;
      en_ret_lock_det  <= en_ret_lock_det_n;
      fastlock_ready   <= fastlock_ready_n;
      ready            <= ready_n;
      loss_of_lock     <= loss_of_lock_n;
      ret_exit_timeout <= ret_exit_timeout_n;
      fault            <= fault_n;
      retry_count      <= retry_count_n;
      lol_count        <= lol_count_n;
    end
  end

  // Next-state and next-output logic; counters clear unless the state counts
  always_comb begin
    state_n            = state;
    count_n            = '0;
    filt_n             = '0;
    pll_en_n           = pll_en;
    pll_reset_n        = pll_reset;
    pll_ret_n          = pll_ret;
    en_lock_det_n      = en_lock_det;
    en_fastlock_n      = en_fastlock;
    en_ret_lock_det_n  = en_ret_lock_det;
    fastlock_ready_n   = fastlock_ready;
    ready_n            = ready;
    loss_of_lock_n     = 1'b0;
    ret_exit_timeout_n = ret_exit_timeout;
    fault_n            = fault;
    retry_count_n      = retry_count;
    lol_count_n        = lol_count;
    go_idle            = 1'b0;

    if (state != IDLE && !enable_s) begin
      go_idle = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          pll_en_n         = 1'b0;
          pll_reset_n      = 1'b1;
          retry_count_n    = '0;
          fastlock_ready_n = 1'b0;
          if (enable_s) begin
            state_n  = BIAS_SETTLE;
            pll_en_n = 1'b1;
          end
        end
        BIAS_SETTLE: begin
          count_n = count + CNT_W'(1);
          if (count == CNT_W'(swi_bias_settle_count)) begin
            count_n       = '0;
            pll_reset_n   = 1'b0;
            en_lock_det_n = 1'b1;
            en_fastlock_n = !swi_skip_fastlock;
            state_n       = swi_skip_fastlock ? LOCKING : FASTLOCKING;
          end
        end
        FASTLOCKING: begin
          filt_n = locked_s ? filt + 8'd1 : 8'd0;
          if (lock_qual) begin
            filt_n           = '0;
            state_n          = PRE_LOCKING;
            en_lock_det_n    = 1'b0;
            en_fastlock_n    = 1'b0;
            fastlock_ready_n = 1'b1;
          end
        end
        PRE_LOCKING: begin
          count_n = count + CNT_W'(1);
          if (count == CNT_W'(swi_pre_locking_count)) begin
            count_n       = '0;
            state_n       = LOCKING;
            en_lock_det_n = 1'b1;
          end
        end
        LOCKING: begin
          filt_n = locked_s ? filt + 8'd1 : 8'd0;
          if (lock_qual) begin
            filt_n             = '0;
            state_n            = PLL_LOCKED;
            ready_n            = 1'b1;
            en_lock_det_n      = !swi_disable_lock_det_after_lock;
            ret_exit_timeout_n = 1'b0;
          end
        end
        PLL_LOCKED: begin
          ready_n       = 1'b1;
          en_lock_det_n = !swi_disable_lock_det_after_lock;
          if (core_ret_s) begin
            state_n       = RETEN;
            pll_ret_n     = 1'b1;
            en_lock_det_n = 1'b0;
            ready_n       = 1'b0;
          end else if (lock_lost) begin
            loss_of_lock_n   = 1'b1;
            lol_count_n      = (lol_count == 8'hFF) ? lol_count : lol_count + 8'd1;
            en_lock_det_n    = 1'b0;
            fastlock_ready_n = 1'b0;
            ready_n          = 1'b0;
            pll_reset_n      = 1'b1;
            if (swi_auto_relock && (retry_count < swi_max_retry)) begin
              retry_count_n = retry_count + RETRY_W'(1);
              state_n       = BIAS_SETTLE;
            end else begin
              state_n  = FAULT;
              pll_en_n = 1'b0;
              fault_n  = 1'b1;
            end
          end
        end
        RETEN: begin
          pll_ret_n = 1'b1;
          // A zero wait parks the counter so training never triggers
          count_n = (swi_ret_per_training_wait == '0) ? '0 : count + CNT_W'(1);
          if (!core_ret_s) begin
            count_n           = '0;
            state_n           = RETEN_LOCKING;
            pll_ret_n         = 1'b0;
            en_ret_lock_det_n = 1'b1;
          end else if ((swi_ret_per_training_wait != '0) && (count == swi_ret_per_training_wait)) begin
            count_n           = '0;
            state_n           = RETEN_PER;
            pll_ret_n         = 1'b0;
            en_ret_lock_det_n = 1'b1;
          end
        end
        RETEN_PER: begin
          count_n = count + CNT_W'(1);
          if (!core_ret_s) begin
            count_n           = '0;
            state_n           = RETEN_LOCKING;
            pll_ret_n         = 1'b0;
            en_ret_lock_det_n = 1'b1;
          end else if (count == swi_ret_per_training_time) begin
            count_n           = '0;
            state_n           = RETEN;
            pll_ret_n         = 1'b1;
            en_ret_lock_det_n = 1'b0;
          end
        end
        RETEN_LOCKING: begin
          count_n = count + CNT_W'(1);
          if (ret_mode_locked_s) begin
            count_n            = '0;
            state_n            = PLL_LOCKED;
            ready_n            = 1'b1;
            en_ret_lock_det_n  = 1'b0;
            en_lock_det_n      = !swi_disable_lock_det_after_lock;
            ret_exit_timeout_n = 1'b0;
          end else if (count == swi_ret_exit_timeout) begin
            ret_exit_timeout_n = 1'b1;
            go_idle            = 1'b1;
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          go_idle = 1'b1;
        end
      endcase
    end

    // Common return to IDLE: PLL held in reset, every enable and status dropped
    if (go_idle) begin
      state_n           = IDLE;
      count_n           = '0;
      filt_n            = '0;
      pll_en_n          = 1'b0;
      pll_reset_n       = 1'b1;
      pll_ret_n         = 1'b0;
      en_lock_det_n     = 1'b0;
      en_fastlock_n     = 1'b0;
      en_ret_lock_det_n = 1'b0;
      fastlock_ready_n  = 1'b0;
      ready_n           = 1'b0;
      fault_n           = 1'b0;
      retry_count_n     = '0;
    end
  end

endmodule

// File: doc/rpll_seq.md
# rpll_seq

Parametrised next-generation RPLL bring-up/retention sequencer. Drives a ring PLL through bias settle, optional fastlock, normal lock, and retention, adding a filtered lock qualifier, automatic relock with a bounded retry count, real periodic retention training, a fault state, and enable-drop abort. It sits between the CSR block (swi_* settings) and the PLL analog macro in the clock subsystem.

## Interface
- CNT_W, 16: width of the main counter and of the retention timing settings.
- RETRY_W, 3: width of the retry limit and retry counter.
- SYNC_STAGES, 2: synchroniser depth for asynchronous inputs; minimum 2.

- clk  in  1  sequencer clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- enable  in  1  async request to run the PLL.
- locked  in  1  async lock detector output.
- core_ret  in  1  async retention request.
- ret_mode_locked  in  1  async retention-mode lock indication.
- swi_bias_settle_count  in  8  BIAS_SETTLE length minus 1.
- swi_pre_locking_count  in  8  PRE_LOCKING length minus 1.
- swi_lock_filt_count  in  8  extra consecutive locked cycles required to qualify lock.
- swi_skip_fastlock  in  1  bypass FASTLOCKING/PRE_LOCKING.
- swi_disable_lock_det_after_lock  in  1  drop en_lock_det and ignore loss of lock in PLL_LOCKED.
- swi_auto_relock  in  1  relock on loss of lock instead of faulting.
- swi_max_retry  in  RETRY_W  maximum automatic relocks.
- swi_ret_per_training_wait  in  CNT_W  RETEN dwell before periodic training; 0 disables training.
- swi_ret_per_training_time  in  CNT_W  RETEN_PER length minus 1.
- swi_ret_exit_timeout  in  CNT_W  RETEN_LOCKING timeout.
- pll_en, pll_reset, pll_ret  out  1  PLL controls.
- en_lock_det, en_fastlock, en_ret_lock_det  out  1  detector and fastlock enables.
- fastlock_ready, ready  out  1  status.
- loss_of_lock  out  1  one-cycle pulse per detected loss.
- ret_exit_timeout  out  1  sticky; cleared on the next entry to PLL_LOCKED.
- fault  out  1  high in FAULT.
- retry_count  out  RETRY_W  relocks since last IDLE.
- lol_count  out  8  saturating loss-of-lock event count; cleared only by reset.
- fsm_state  out  4  current state encoding.

## Operation
- States and encodings: IDLE=0, BIAS_SETTLE=1, FASTLOCKING=2, PRE_LOCKING=3, LOCKING=4, PLL_LOCKED=5, RETEN=6, RETEN_PER=7, RETEN_LOCKING=8, FAULT=9.
- Reset: state IDLE. pll_reset=1. All other outputs and counters are 0.
- All four async inputs pass through SYNC_STAGES flops that reset to 0. In this section, \*_s denotes the synchronised signal.
- Priority 1 (any non-IDLE state): enable_s=0 forces IDLE with pll_en=0, pll_reset=1, and all enables, ready and fault cleared.
- IDLE:
  - Holds pll_en=0, pll_reset=1, retry_count=0, fastlock_ready=0.
  - enable_s=1 -> BIAS_SETTLE with pll_en=1 and count=0.
- BIAS_SETTLE:
  - count increments; the exit condition is count==swi_bias_settle_count, zero-extended.
  - Normal exit -> FASTLOCKING with pll_reset=0, en_lock_det=1, en_fastlock=1.
  - If swi_skip_fastlock=1, exit instead -> LOCKING with pll_reset=0 and en_lock_det=1.
- Lock qualifier:
  - filt counter (8 bits) is active in FASTLOCKING and LOCKING.
  - It increments while locked_s=1, clears when locked_s=0, and clears on entry to either state.
  - Lock is qualified when locked_s=1 and filt==swi_lock_filt_count.
- FASTLOCKING: qualified lock -> PRE_LOCKING with en_lock_det=0, en_fastlock=0, fastlock_ready=1, count=0.
- PRE_LOCKING: when count==swi_pre_locking_count -> LOCKING with en_lock_det=1.
- LOCKING: qualified lock -> PLL_LOCKED with ready=1.
- PLL_LOCKED:
  - Outputs: ready=1; en_lock_det=~swi_disable_lock_det_after_lock; ret_exit_timeout clears on entry.
  - Checks are evaluated in this order; the first match wins:
    - core_ret_s=1 -> RETEN with pll_ret=1, en_lock_det=0, ready=0, count=0. core_ret_s wins over a simultaneous loss of lock, so no pulse is issued.
    - Loss of lock: locked_s=0 and lock detect not disabled. Always pulses loss_of_lock and increments lol_count (saturates at 255). Then:
      - If swi_auto_relock=1 and retry_count<swi_max_retry: retry_count+1, then -> BIAS_SETTLE with pll_reset=1, en_lock_det=0, fastlock_ready=0, ready=0, count=0. pll_en stays 1.
      - Otherwise -> FAULT with pll_en=0, pll_reset=1, fault=1, ready=0.
- RETEN:
  - pll_ret=1; count increments.
  - core_ret_s=0 -> RETEN_LOCKING. This takes priority over training entry.
  - Otherwise, when count==swi_ret_per_training_wait and the wait is nonzero -> RETEN_PER with pll_ret=0, en_ret_lock_det=1, count=0.
  - With wait=0, count saturates at 0 and training never occurs.
- RETEN_PER:
  - When count==swi_ret_per_training_time -> RETEN with pll_ret=1, en_ret_lock_det=0, count=0.
  - core_ret_s=0 -> RETEN_LOCKING.
- Entry to RETEN_LOCKING (from RETEN or RETEN_PER): pll_ret=0, en_ret_lock_det=1, count=0.
- RETEN_LOCKING:
  - ret_mode_locked_s=1 -> PLL_LOCKED with ready=1, en_ret_lock_det=0, en_lock_det per the disable bit. This takes priority over timeout.
  - Otherwise, when count==swi_ret_exit_timeout: ret_exit_timeout=1, -> IDLE with pll_en=0, pll_reset=1. If enable_s is still 1, the sequencer restarts normally.
- FAULT: held until enable_s=0.
- Width rules: count is CNT_W bits. 8-bit settings are zero-extended. All comparisons are equality.

## Timing
- All outputs are registered and update on the same edge as the state change they accompany.
- Input-to-state latency: SYNC_STAGES cycles to reach *_s, plus 1 cycle for the state update.
- A counted state with setting N dwells exactly N+1 cycles. Example: swi_bias_settle_count=0 gives 1 cycle in BIAS_SETTLE.
- Lock qualification takes swi_lock_filt_count+1 consecutive cycles of locked_s=1.
- loss_of_lock is high for exactly 1 cycle per event.
- reset_n low at any edge returns every register to its reset value on that edge, including mid-retention.

## Test plan
- Bring-up: settle=3, pre=2, filt=2, locked tied high -> BIAS_SETTLE 4 cycles, FASTLOCKING 3, PRE_LOCKING 3, LOCKING 3; then ready=1 and fsm_state=5.
- Filter reset: filt=4, locked toggles low after 3 high cycles in LOCKING -> no transition until 5 consecutive high cycles.
- Auto relock: swi_auto_relock=1, swi_max_retry=2, three locked drops in PLL_LOCKED -> two relocks (retry_count=2), then FAULT with fault=1, pll_en=0; lol_count=3.
- Retention training: wait=10, time=4, core_ret held high -> pll_ret low for 5 cycles every 11 RETEN cycles. Dropping core_ret mid-RETEN_PER with ret_mode_locked high -> PLL_LOCKED, ready=1.
- Exit timeout: timeout=20, ret_mode_locked stays 0 -> after 21 cycles ret_exit_timeout=1 and fsm_state=0, then a restart; ret_exit_timeout clears at the next PLL_LOCKED.
- Aborts: enable dropped in RETEN -> IDLE SYNC_STAGES+1 cycles later with pll_reset=1. reset_n low mid-LOCKING -> all outputs at reset values on the next edge.
